// File: rtl/mymv_interp_gate.sv
// Trigger-gated linear interpolator: replays coarse samples at the fine trig rate as exact linear ramps.
// Optional sticky underrun/overrun status is compiled in with MV_INTERP_STATUS_EN.
module mymv_interp_gate #(
    parameter int STEPS = 4,
    parameter int K     = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_vld,
    input  logic signed [31:0] din,
    input  logic               trig,
    output logic signed [31:0] dout,
    output logic               dout_vld,
    output logic               underrun,
    output logic               overrun,
    input  logic               flag_clr
);

    localparam int AW = 34 + K;
    localparam logic [K:0] STEPS_W = STEPS[K:0];

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]           state, state_mid;
    logic signed [31:0]   tgt;
    logic signed [AW-1:0] acc, acc_mid, acc_next, base;
    logic signed [33:0]   delta, delta_mid;
    logic [K:0]           step, step_mid, step_next;
    logic                 set_u, set_o, emit;
    logic signed [31:0]   dout_next;

    // A din_vld is applied first (segment load), then a same-cycle trig steps the new segment.
    always_comb begin
        base      = (AW'(tgt)) <<< K;
        state_mid = state;
        acc_mid   = acc;
        delta_mid = delta;
        step_mid  = step;
        acc_next  = acc;
        step_next = step;
        set_u     = 1'b0;
        set_o     = 1'b0;
        emit      = 1'b0;
        if (state == IDLE) begin
            if (din_vld) begin
                acc_next  = (AW'(din)) <<< K;
                step_next = STEPS_W;
                state_mid = PRIME;
            end
        end else begin
            if (din_vld) begin
                if (step < STEPS_W) begin
                    acc_mid = base;
                    set_o   = 1'b1;
                end
                delta_mid = 34'(din) - 34'(tgt);
                step_mid  = '0;
                state_mid = RUN;
            end
            acc_next  = acc_mid;
            step_next = step_mid;
            if (trig) begin
                emit = 1'b1;
                if (state_mid == RUN) begin
                    if (step_mid < STEPS_W) begin
                        acc_next  = acc_mid + AW'(delta_mid);
                        step_next = step_mid + (K+1)'(1);
                    end else begin
                        set_u = 1'b1;
                    end
                end
            end
        end
        dout_next = 32'(acc_next >>> K);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tgt      <= '0;
            acc      <= '0;
            delta    <= '0;
            step     <= STEPS_W;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            state    <= state_mid;
            acc      <= acc_next;
            delta    <= delta_mid;
            step     <= step_next;
            dout_vld <= emit;
            if (din_vld)
                tgt <= din;
            if (emit)
                dout <= dout_next;
        end
    end

`ifdef MV_INTERP_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (set_u)
                underrun <= 1'b1;
            else if (flag_clr)
                underrun <= 1'b0;
            if (set_o)
                overrun <= 1'b1;
            else if (flag_clr)
                overrun <= 1'b0;
        end
    end
`else
    logic unused_status;
    assign unused_status = flag_clr | set_u | set_o;
    assign underrun      = 1'b0;
    assign overrun       = 1'b0;
`endif

endmodule

// File: tb/tb_mymv_interp_gate.sv
// Bench for mymv_interp_gate: directed vector table plus randomized traffic against a ramp-equation model.
module tb_mymv_interp_gate;

    localparam int STEPS = 4;
`ifdef MV_INTERP_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               din_vld = 1'b0;
    logic signed [31:0] din = '0;
    logic               trig = 1'b0;
    logic               flag_clr = 1'b0;
    logic signed [31:0] dout;
    logic               dout_vld, underrun, overrun;

    always #5 clk = ~clk;

    mymv_interp_gate #(.STEPS(STEPS)) dut (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .trig(trig),
        .dout(dout), .dout_vld(dout_vld), .underrun(underrun), .overrun(overrun),
        .flag_clr(flag_clr)
    );

    typedef struct {
        bit rst; bit vld; int din; bit trig; bit clr;
        int e_dout; bit e_vld; bit e_u; bit e_o;
    } vec_t;
    vec_t tbl[$];

    int errors = 0;
    int checks = 0;

    // Reference: output = prev + floor(k*(tgt-prev)/STEPS), k triggers into the segment.
    int      m_phase;
    longint  m_prev, m_tgt;
    int      m_k;
    bit      m_u, m_o, m_vld;
    int      m_dout;

    function automatic longint floordiv(longint n, longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    task automatic model_step(input bit r, input bit v, input int d, input bit t, input bit c);
        bit su, so;
        su = 0; so = 0;
        if (r) begin
            m_phase = 0; m_prev = 0; m_tgt = 0; m_k = STEPS;
            m_u = 0; m_o = 0; m_vld = 0; m_dout = 0;
            return;
        end
        m_vld = 0;
        if (m_phase == 0) begin
            if (v) begin
                m_tgt = d; m_prev = d; m_k = STEPS; m_phase = 1;
            end
        end else begin
            if (v) begin
                if (m_phase == 2 && m_k < STEPS) so = 1;
                m_prev = m_tgt; m_tgt = d; m_k = 0; m_phase = 2;
            end
            if (t) begin
                if (m_phase == 2) begin
                    if (m_k < STEPS) m_k++;
                    else su = 1;
                    m_dout = int'(m_prev + floordiv(longint'(m_k) * (m_tgt - m_prev), STEPS));
                end else begin
                    m_dout = int'(m_tgt);
                end
                m_vld = 1;
            end
        end
        if (STATUS) begin
            m_u = su ? 1'b1 : (c ? 1'b0 : m_u);
            m_o = so ? 1'b1 : (c ? 1'b0 : m_o);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v, input int d, input bit t, input bit c);
        rst = r; din_vld = v; din = d; trig = t; flag_clr = c;
        @(posedge clk);
        #1;
        model_step(r, v, d, t, c);
    endtask

    task automatic add(input bit r, input bit v, input int d, input bit t, input bit c,
                       input int ed, input bit ev, input bit eu, input bit eo);
        vec_t x;
        x.rst = r; x.vld = v; x.din = d; x.trig = t; x.clr = c;
        x.e_dout = ed; x.e_vld = ev; x.e_u = eu; x.e_o = eo;
        tbl.push_back(x);
    endtask

    initial begin
        //   rst vld din  trig clr   dout vld u o
        add(1, 0, 0,    0, 0,    0,    0, 0, 0);
        add(0, 0, 0,    1, 0,    0,    0, 0, 0);
        add(0, 0, 0,    1, 0,    0,    0, 0, 0);
        add(0, 0, 0,    1, 0,    0,    0, 0, 0);
        add(0, 1, 100,  0, 0,    0,    0, 0, 0);
        add(0, 0, 0,    1, 0,    100,  1, 0, 0);
        add(0, 1, 500,  0, 0,    100,  0, 0, 0);
        add(0, 0, 0,    1, 0,    200,  1, 0, 0);
        add(0, 0, 0,    1, 0,    300,  1, 0, 0);
        add(0, 0, 0,    1, 0,    400,  1, 0, 0);
        add(0, 0, 0,    1, 0,    500,  1, 0, 0);
        add(0, 0, 0,    1, 0,    500,  1, 1, 0);
        add(0, 0, 0,    0, 0,    500,  0, 1, 0);
        add(0, 0, 0,    0, 1,    500,  0, 0, 0);
        add(0, 1, -300, 0, 0,    500,  0, 0, 0);
        add(0, 0, 0,    1, 0,    300,  1, 0, 0);
        add(0, 0, 0,    1, 0,    100,  1, 0, 0);
        add(0, 0, 0,    1, 0,    -100, 1, 0, 0);
        add(0, 0, 0,    1, 0,    -300, 1, 0, 0);
        add(0, 1, 0,    0, 0,    -300, 0, 0, 0);
        add(0, 1, 7,    0, 0,    -300, 0, 0, 1);
        add(0, 0, 0,    0, 1,    -300, 0, 0, 0);
        add(0, 0, 0,    1, 0,    1,    1, 0, 0);
        add(0, 0, 0,    1, 0,    3,    1, 0, 0);
        add(0, 0, 0,    1, 0,    5,    1, 0, 0);
        add(0, 0, 0,    1, 0,    7,    1, 0, 0);
        add(0, 1, 0,    0, 0,    7,    0, 0, 0);
        add(0, 0, 0,    1, 0,    5,    1, 0, 0);
        add(0, 0, 0,    1, 0,    3,    1, 0, 0);
        add(0, 0, 0,    1, 0,    1,    1, 0, 0);
        add(0, 0, 0,    1, 0,    0,    1, 0, 0);
        add(0, 1, 400,  0, 0,    0,    0, 0, 0);
        add(0, 0, 0,    1, 0,    100,  1, 0, 0);
        add(0, 0, 0,    1, 0,    200,  1, 0, 0);
        add(0, 1, 0,    1, 0,    300,  1, 0, 1);
        add(0, 0, 0,    1, 0,    200,  1, 0, 1);
        add(0, 0, 0,    1, 0,    100,  1, 0, 1);
        add(0, 0, 0,    1, 0,    0,    1, 0, 1);
        add(0, 0, 0,    1, 0,    0,    1, 1, 1);
        add(0, 1, 1000, 0, 0,    0,    0, 1, 1);
        add(0, 0, 0,    1, 0,    250,  1, 1, 1);
        add(0, 1, 2000, 0, 1,    250,  0, 0, 1);
        add(0, 0, 0,    1, 0,    1250, 1, 0, 1);
        add(0, 0, 0,    1, 0,    1500, 1, 0, 1);
        add(1, 0, 0,    1, 0,    0,    0, 0, 0);
        add(0, 0, 0,    1, 0,    0,    0, 0, 0);
        add(0, 1, 5,    1, 0,    0,    0, 0, 0);
        add(0, 0, 0,    1, 0,    5,    1, 0, 0);
        add(0, 1, -3,   1, 0,    3,    1, 0, 0);
        add(0, 0, 0,    1, 0,    1,    1, 0, 0);

        #2;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].trig, tbl[i].clr);
            check($sformatf("row%0d dout", i), dout, tbl[i].e_dout);
            check($sformatf("row%0d dout_vld", i), int'(dout_vld), int'(tbl[i].e_vld));
            check($sformatf("row%0d underrun", i), int'(underrun), int'(tbl[i].e_u & STATUS));
            check($sformatf("row%0d overrun", i), int'(overrun), int'(tbl[i].e_o & STATUS));
        end

        drive(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r, v, t, c;
            int d;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) d = int'($urandom);
            else d = $urandom_range(0, 2000) - 1000;
            drive(r, v, d, t, c);
            check($sformatf("rnd%0d dout", n), dout, m_dout);
            check($sformatf("rnd%0d dout_vld", n), int'(dout_vld), int'(m_vld));
            check($sformatf("rnd%0d underrun", n), int'(underrun), int'(m_u));
            check($sformatf("rnd%0d overrun", n), int'(overrun), int'(m_o));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
